// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampled UART receiver.
// Holds the receiver FSM encoding, parity-type codes and the 2-of-3 vote helper.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_IDLE = 3'd5
    } rx_state_t;

    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_oversampled_if.sv
// Delivery interface between the UART receiver and its consumer.
interface uart_rx_oversampled_if;

    // Transfer happens on a clock edge where rx_valid and rx_ready are both high;
    // rx_data, frame_err and parity_err are stable while rx_valid waits for rx_ready.
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       parity_err;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output parity_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  parity_err,
        output rx_ready
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Free-running oversample tick: one-cycle pulse every CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks.
module uart_baud_gen #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver: majority-voted bits, optional parity, 1-2 stop bits,
// break detection and a valid/ready delivery port with overrun reporting.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ  = 100_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_TYPE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         RX,
    uart_rx_oversampled_if.master        bus,
    output logic                         overrun_err,
    output logic                         break_det,
    output logic                         rx_busy,
    output rx_state_t                    state_dbg
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_PRE  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_VOTE = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [2:0]    B_LAST = 3'(DATA_BITS - 1);
    localparam logic          PAR_INV   = (PARITY_TYPE == PARITY_ODD);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    logic                 tick;
    logic                 sync1;
    logic                 rx_s;
    logic                 rx_prev;
    rx_state_t            state;
    logic [SW-1:0]        sample_cnt;
    logic [2:0]           bit_cnt;
    logic                 stop_cnt;
    logic                 smp_pre;
    logic                 smp_mid;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_acc;
    logic                 any_one;
    logic                 parity_bad;
    logic                 frame_bad;

    logic voted;
    logic accept;
    logic at_vote;
    logic at_last;

    uart_baud_gen #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // The third vote is the live sample taken on the same tick the decision is made.
    assign voted   = maj3(smp_pre, smp_mid, rx_s);
    assign accept  = bus.rx_valid && bus.rx_ready;
    assign at_vote = tick && (sample_cnt == S_VOTE);
    assign at_last = tick && (sample_cnt == S_LAST);

    assign rx_busy   = (state != RX_IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1          <= 1'b1;
            rx_s           <= 1'b1;
            rx_prev        <= 1'b1;
            state          <= RX_IDLE;
            sample_cnt     <= '0;
            bit_cnt        <= '0;
            stop_cnt       <= 1'b0;
            smp_pre        <= 1'b1;
            smp_mid        <= 1'b1;
            shift_reg      <= '0;
            par_acc        <= 1'b0;
            any_one        <= 1'b0;
            parity_bad     <= 1'b0;
            frame_bad      <= 1'b0;
            bus.rx_data    <= '0;
            bus.rx_valid   <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.parity_err <= 1'b0;
            overrun_err    <= 1'b0;
            break_det      <= 1'b0;
        end else begin
            sync1       <= RX;
            rx_s        <= sync1;
            rx_prev     <= rx_s;
            overrun_err <= 1'b0;
            break_det   <= 1'b0;

            if (accept) begin
                bus.rx_valid <= 1'b0;
            end

            if (tick) begin
                sample_cnt <= (sample_cnt == S_LAST) ? '0 : sample_cnt + 1'b1;
                if (sample_cnt == S_PRE) smp_pre <= rx_s;
                if (sample_cnt == S_MID) smp_mid <= rx_s;
            end

            case (state)
                RX_IDLE: begin
                    sample_cnt <= '0;
                    if (rx_prev && !rx_s) begin
                        state      <= RX_START;
                        bit_cnt    <= '0;
                        stop_cnt   <= 1'b0;
                        par_acc    <= 1'b0;
                        any_one    <= 1'b0;
                        parity_bad <= 1'b0;
                        frame_bad  <= 1'b0;
                    end
                end

                RX_START: begin
                    if (tick && (sample_cnt == S_MID) && rx_s) begin
                        state <= RX_IDLE;
                    end else if (at_last) begin
                        state <= RX_DATA;
                    end
                end

                RX_DATA: begin
                    if (at_vote) begin
                        shift_reg <= {voted, shift_reg[DATA_BITS-1:1]};
                        par_acc   <= par_acc ^ voted;
                        any_one   <= any_one | voted;
                    end
                    if (at_last) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == B_LAST) begin
                            state <= (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                        end
                    end
                end

                RX_PARITY: begin
                    if (at_vote) begin
                        parity_bad <= ((par_acc ^ PAR_INV) != voted);
                        any_one    <= any_one | voted;
                    end
                    if (at_last) begin
                        state <= RX_STOP;
                    end
                end

                RX_STOP: begin
                    // Break wins over frame delivery when everything up to the first stop bit was low.
                    if (at_vote) begin
                        if (!stop_cnt && !voted && !any_one) begin
                            break_det <= 1'b1;
                            state     <= RX_WAIT_IDLE;
                        end else if (stop_cnt == STOP_LAST) begin
                            state <= RX_IDLE;
                            if (!bus.rx_valid || bus.rx_ready) begin
                                bus.rx_data    <= 8'(shift_reg);
                                bus.frame_err  <= frame_bad | ~voted;
                                bus.parity_err <= parity_bad;
                                bus.rx_valid   <= 1'b1;
                            end else begin
                                overrun_err <= 1'b1;
                            end
                        end else begin
                            frame_bad <= frame_bad | ~voted;
                        end
                    end else if (at_last) begin
                        stop_cnt <= 1'b1;
                    end
                end

                RX_WAIT_IDLE: begin
                    sample_cnt <= '0;
                    if (rx_s) begin
                        state <= RX_IDLE;
                    end
                end

                default: begin
                    state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx_oversampled.md
UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

Interface
REQ-001 Parameter CLOCK_FREQ, default 100_000_000, system clock in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, line bit rate.
REQ-003 Parameter OVERSAMPLE, default 16, samples per bit (even, >=8).
REQ-004 Parameter DATA_BITS, default 8, data bits per frame (5-8).
REQ-005 Parameter PARITY_EN, default 0, 1 = parity bit present.
REQ-006 Parameter PARITY_TYPE, default 0, 0 = even, 1 = odd.
REQ-007 Parameter STOP_BITS, default 1, stop bits checked (1 or 2).
REQ-008 Clocking and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-009 clk  input  1  system clock.
REQ-010 rst_n  input  1  asynchronous active-low reset.
REQ-011 RX  input  1  asynchronous UART line, idle high.
REQ-012 rx_data  output  8  received byte, unused upper bits zero.
REQ-013 rx_valid  output  1  rx_data/error flags valid; held until accepted.
REQ-014 rx_ready  input  1  consumer accepts when rx_valid and rx_ready are both high.
REQ-015 frame_err  output  1  delivered frame had a low stop bit; qualified by rx_valid.
REQ-016 parity_err  output  1  delivered frame failed parity; qualified by rx_valid.
REQ-017 overrun_err  output  1  one-cycle pulse: completed frame dropped.
REQ-018 break_det  output  1  one-cycle pulse: break condition detected.
REQ-019 rx_busy  output  1  high in every state except IDLE.

Function
REQ-020 Sample tick SHALL pulse one cycle every CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks (integer division), free-running.
REQ-021 RX SHALL pass a 2-flop synchronizer; all decisions use the synchronized value.
REQ-022 FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-023 IDLE -> START on a synchronized high-to-low transition; sample counter cleared.
REQ-024 Sample counter counts ticks 0..OVERSAMPLE-1 per bit; bit value = majority of samples OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1.
REQ-025 START: at tick OVERSAMPLE/2, line high -> IDLE (glitch, no output); otherwise continue and go to DATA at end of bit.
REQ-026 DATA: bits shifted LSB first; after DATA_BITS bits -> PARITY if PARITY_EN, else STOP.
REQ-027 PARITY: computed parity (XOR of data, inverted if PARITY_TYPE=1) compared with voted bit; mismatch sets parity_err for this frame.
REQ-028 STOP: each stop bit voted; any low stop bit sets frame_err; frame completes at the mid-bit vote of the last stop bit -> IDLE.
REQ-029 Break: all data bits 0, parity bit (if any) 0 and first stop bit 0 -> break_det pulse, no rx_valid, go to WAIT_IDLE.
REQ-030 WAIT_IDLE -> IDLE once synchronized RX is high.
REQ-031 Completion with rx_valid low: load rx_data, frame_err, parity_err; rx_valid=1 next cycle.
REQ-032 Completion with rx_valid high and rx_ready low: overrun_err pulse; held data and flags unchanged.
REQ-033 Completion in the same cycle as an accept: new frame loaded, rx_valid stays 1, no overrun.
REQ-034 Accept without completion: rx_valid cleared next cycle.
REQ-035 Frames with frame_err or parity_err SHALL still be delivered through rx_valid.

Reset
REQ-036 On rst_n low: state IDLE, rx_data=0, rx_valid=0, all error outputs 0, rx_busy=0, counters 0, synchronizer flops 1.
REQ-037 Reset mid-frame SHALL abandon the frame without output; after release, reception starts at the next falling edge.

Structure
REQ-038 Package uart_pkg SHALL hold the rx state enum and the parity-type constants (PARITY_EVEN, PARITY_ODD).
REQ-039 Tick generator SHALL be sub-module uart_baud_gen (parameters CLOCK_FREQ, BAUD_RATE, OVERSAMPLE; output tick).

Verification
REQ-040 100 MHz, 115200, 8N1: send 0xA5, rx_ready=1 -> rx_data=0xA5, rx_valid pulse, no errors; tick period 54 clocks.
REQ-041 8E1: send 0x07 with parity bit 0 -> rx_data=0x07, parity_err=1, rx_valid=1.
REQ-042 8N1: send 0x3C with stop bit 0 -> rx_data=0x3C, frame_err=1; send 0x00 with stop bit 0 -> break_det pulse, no rx_valid, next frame 0x55 received after line returns high.
REQ-043 rx_ready=0: send 0x11 then 0x22 -> overrun_err pulse, rx_data stays 0x11 until accepted.
REQ-044 RX low pulse of 3 sample ticks -> no rx_valid, FSM back in IDLE; single-tick glitch at sample OVERSAMPLE/2 inside a data bit -> vote rejects it, byte correct.
REQ-045 rst_n asserted during DATA of 0x5A -> all outputs 0; following 0x81 received correctly.
